// File: rtl/sfr_bit_ctrl_if.sv
// sfr_bit_ctrl_if -- request/byte-bus bundle for the SFR bit-operation engine.
//   master : requester + byte memory side (drives start/op/bit_addr/carry_in/rd_data)
//   slave  : sfr_bit_ctrl (drives byte_addr, rd_en, wr_en, wr_data, carry_out,
//            carry_we, bit_out, busy, done)
interface sfr_bit_ctrl_if;
  logic       start;
  logic [2:0] op;
  logic [7:0] bit_addr;
  logic       carry_in;
  logic [7:0] rd_data;
  logic [7:0] byte_addr;
  logic       rd_en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       carry_out;
  logic       carry_we;
  logic       bit_out;
  logic       busy;
  logic       done;

  modport master (
    output start, op, bit_addr, carry_in, rd_data,
    input  byte_addr, rd_en, wr_en, wr_data, carry_out, carry_we, bit_out, busy, done
  );

  modport slave (
    input  start, op, bit_addr, carry_in, rd_data,
    output byte_addr, rd_en, wr_en, wr_data, carry_out, carry_we, bit_out, busy, done
  );
endinterface

// File: rtl/sfr_bit_ctrl.sv
// sfr_bit_ctrl -- 8051-style bit operation engine (read-modify-write on a byte).
//   clock : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : sfr_bit_ctrl_if.slave -- request (start/op/bit_addr/carry_in),
//           byte bus (byte_addr/rd_en/rd_data/wr_en/wr_data), carry update
//           (carry_out/carry_we), status (bit_out/busy/done)
// Sequence: IDLE -> READ -> CAPTURE -> WRITE -> DONE, one cycle each.
module sfr_bit_ctrl (
  input  logic            clock,
  input  logic            reset,
  sfr_bit_ctrl_if.slave   bus
);
  typedef enum logic [2:0] {IDLE, READ, CAPTURE, WRITE, DONE} state_t;

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] addr;
    logic       cy;
  } req_t;

  localparam logic [2:0] OP_CLR  = 3'd0;
  localparam logic [2:0] OP_SETB = 3'd1;
  localparam logic [2:0] OP_CPL  = 3'd2;
  localparam logic [2:0] OP_MOVB = 3'd3;
  localparam logic [2:0] OP_MOVC = 3'd4;
  localparam logic [2:0] OP_ANL  = 3'd5;
  localparam logic [2:0] OP_ORL  = 3'd6;

  state_t     state, state_nxt;
  req_t       req;
  logic [7:0] cap_byte;
  logic       bit_q;
  logic [2:0] bit_idx;
  logic [7:0] map_addr;
  logic [7:0] new_byte;
  logic       cy_new;
  logic       is_wr, is_cy;

  // Bit-addressable RAM lives at 0x20..0x2F; SFRs are every eighth address from 0x80.
  assign bit_idx  = req.addr[2:0];
  assign map_addr = req.addr[7] ? {req.addr[7:3], 3'b000}
                                : (8'h20 + {4'h0, req.addr[6:3]});
  assign is_wr    = (req.op <= OP_MOVB);
  assign is_cy    = (req.op == OP_MOVC) || (req.op == OP_ANL) || (req.op == OP_ORL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      req      <= '0;
      cap_byte <= 8'h00;
      bit_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start)
        req <= '{op: bus.op, addr: bus.bit_addr, cy: bus.carry_in};
      // rd_data arrives the cycle after rd_en, i.e. during CAPTURE.
      if (state == CAPTURE) begin
        cap_byte <= bus.rd_data;
        bit_q    <= bus.rd_data[bit_idx];
      end
    end
  end

  always_comb begin
    new_byte = cap_byte;
    case (req.op)
      OP_CLR:  new_byte[bit_idx] = 1'b0;
      OP_SETB: new_byte[bit_idx] = 1'b1;
      OP_CPL:  new_byte[bit_idx] = ~cap_byte[bit_idx];
      OP_MOVB: new_byte[bit_idx] = req.cy;
      default: new_byte = cap_byte;
    endcase
  end

  always_comb begin
    cy_new = 1'b0;
    case (req.op)
      OP_MOVC: cy_new = bit_q;
      OP_ANL:  cy_new = req.cy & bit_q;
      OP_ORL:  cy_new = req.cy | bit_q;
      default: cy_new = 1'b0;
    endcase
  end

  // Outputs decode from state alone, so an async reset drops every strobe at once.
  always_comb begin
    state_nxt     = state;
    bus.byte_addr = 8'h00;
    bus.rd_en     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_data   = 8'h00;
    bus.carry_out = 1'b0;
    bus.carry_we  = 1'b0;
    bus.busy      = 1'b1;
    bus.done      = 1'b0;
    case (state)
      IDLE: begin
        bus.busy = 1'b0;
        if (bus.start) state_nxt = READ;
      end
      READ: begin
        bus.byte_addr = map_addr;
        bus.rd_en     = 1'b1;
        state_nxt     = CAPTURE;
      end
      CAPTURE: begin
        bus.byte_addr = map_addr;
        state_nxt     = WRITE;
      end
      WRITE: begin
        bus.byte_addr = map_addr;
        if (is_wr) begin
          bus.wr_en   = 1'b1;
          bus.wr_data = new_byte;
        end
        if (is_cy) begin
          bus.carry_we  = 1'b1;
          bus.carry_out = cy_new;
        end
        state_nxt = DONE;
      end
      DONE: begin
        bus.done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.bit_out = bit_q;
endmodule

// File: doc/sfr_bit_ctrl.md
SFR_BIT_CTRL -- requirements
Module: sfr_bit_ctrl

Interface
REQ-001 SHALL have port clock, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port start, input, 1 bit: request a bit operation; sampled only in IDLE.
REQ-004 SHALL have port op, input, 3 bits: 0 CLR, 1 SETB, 2 CPL, 3 MOV bit,C, 4 MOV C,bit, 5 ANL C,bit, 6 ORL C,bit, 7 TEST.
REQ-005 SHALL have port bit_addr, input, 8 bits: 8051 bit address.
REQ-006 SHALL have port carry_in, input, 1 bit: current CY.
REQ-007 SHALL have port rd_data, input, 8 bits: byte returned one cycle after rd_en.
REQ-008 SHALL have port byte_addr, output, 8 bits: byte address for read and write.
REQ-009 SHALL have ports rd_en and wr_en, outputs, 1 bit each: byte read and write strobes.
REQ-010 SHALL have port wr_data, output, 8 bits: modified byte.
REQ-011 SHALL have ports carry_out and carry_we, outputs, 1 bit each: new CY value and its one-cycle load strobe.
REQ-012 SHALL have port bit_out, output, 1 bit: value of the addressed bit as read.
REQ-013 SHALL have ports busy and done, outputs, 1 bit each: busy while not IDLE; done is a one-cycle completion pulse.

Function
REQ-014 SHALL map bit_addr<8'h80 to byte_addr 8'h20+bit_addr[6:3], and bit_addr>=8'h80 to byte_addr {bit_addr[7:3],3'b000}; bit index = bit_addr[2:0].
REQ-015 SHALL implement an FSM with states IDLE -> READ -> CAPTURE -> WRITE -> DONE -> IDLE, one cycle each.
REQ-016 SHALL latch op, bit_addr and carry_in in IDLE when start=1, then enter READ; start SHALL be ignored in every other state.
REQ-017 SHALL hold byte_addr stable from READ through WRITE.
REQ-018 SHALL assert rd_en only in READ.
REQ-019 SHALL register rd_data in CAPTURE and set bit_out to the indexed bit; bit_out holds until the next CAPTURE.
REQ-020 SHALL, in WRITE, for ops 0-3, assert wr_en for one cycle with wr_data = captured byte with only the indexed bit changed: 0 clears it, 1 sets it, 2 inverts it, 3 sets it to the latched carry.
REQ-021 SHALL, in WRITE, for ops 4-6, assert carry_we for one cycle with carry_out = bit (op 4), latched carry AND bit (op 5), or latched carry OR bit (op 6); wr_en SHALL stay 0.
REQ-022 SHALL, for op 7, assert neither wr_en nor carry_we; only bit_out updates.
REQ-023 SHALL pulse done in DONE; busy=1 in READ, CAPTURE, WRITE and DONE.
REQ-024 SHALL give a latency from start accept to done of 4 cycles, with a minimum start-to-start spacing of 5 cycles.
REQ-025 SHALL never assert wr_en and carry_we in the same cycle, nor rd_en together with either.
REQ-026 SHALL deassert wr_data, carry_out and byte_addr to 0 in IDLE.

Reset
REQ-027 SHALL, while reset=0, force state IDLE and all outputs to 0 (byte_addr 8'h00, wr_data 8'h00, bit_out 0, busy 0, done 0).
REQ-028 SHALL abort any operation when reset is asserted mid-operation, with no wr_en or carry_we pulse after assertion.
REQ-029 SHALL accept start again on the first rising edge after reset deasserts.

Verification
REQ-030 SHALL cover: SETB bit_addr 8'hD5 with rd_data 8'h00 -> rd_en at addr 8'hD0, then wr_en with wr_data 8'h20, done 4 cycles after start.
REQ-031 SHALL cover: CLR bit_addr 8'h07 with rd_data 8'hFF -> byte_addr 8'h20, wr_data 8'h7F.
REQ-032 SHALL cover: CPL bit_addr 8'h7A with rd_data 8'h04 -> byte_addr 8'h2F, wr_data 8'h00; MOV bit,C at 8'hE3 with carry_in 1 and rd_data 8'h00 -> byte_addr 8'hE0, wr_data 8'h08.
REQ-033 SHALL cover: ANL C,bit at 8'hD7 with carry_in 1 and rd_data 8'h00 -> carry_we pulse with carry_out 0, no wr_en; ORL with rd_data 8'h80 -> carry_out 1.
REQ-034 SHALL cover: start held high continuously -> operations accepted exactly every 5 cycles; TEST op -> bit_out correct, no write strobes.
REQ-035 SHALL cover: reset asserted during CAPTURE -> busy 0 immediately, no wr_en, next start processed normally.
